// File: rtl/vec_isa_pkg.sv
// Shared vector ISA definitions: opcodes, field positions and encode/classify helpers.
// The issue-side encoder and the decoder both import this package.
package vec_isa_pkg;

    localparam logic [4:0] OP_VLOAD  = 5'd0;
    localparam logic [4:0] OP_VSTORE = 5'd1;
    localparam logic [4:0] OP_VADD   = 5'd2;
    localparam logic [4:0] OP_VSUB   = 5'd3;
    localparam logic [4:0] OP_VMUL   = 5'd4;
    localparam logic [4:0] OP_VAND   = 5'd5;
    localparam logic [4:0] OP_VOR    = 5'd6;
    localparam logic [4:0] OP_VXOR   = 5'd7;
    localparam logic [4:0] OP_VSLL   = 5'd8;
    localparam logic [4:0] OP_VSRL   = 5'd9;
    localparam logic [4:0] OP_VSRA   = 5'd10;
    localparam logic [4:0] OP_VMIN   = 5'd11;
    localparam logic [4:0] OP_VMAX   = 5'd12;
    localparam logic [4:0] OP_VMINU  = 5'd13;
    localparam logic [4:0] OP_VMAXU  = 5'd14;
    localparam logic [4:0] OP_VSLT   = 5'd15;

    localparam int OPCODE_LSB = 27;
    localparam int VD_LSB     = 21;
    localparam int VS1_LSB    = 16;
    localparam int VS2_LSB    = 11;

    typedef enum logic {
        ST_ISSUE = 1'b0,
        ST_GAP   = 1'b1
    } issue_state_t;

    // Bit 26 and bits 10:0 are reserved and always encode as zero.
    function automatic logic [31:0] encode_instr(input logic [4:0] opcode,
                                                 input logic [4:0] vd,
                                                 input logic [4:0] vs1,
                                                 input logic [4:0] vs2);
        logic [31:0] w;
        w = '0;
        w[OPCODE_LSB +: 5] = opcode;
        w[VD_LSB     +: 5] = vd;
        w[VS1_LSB    +: 5] = vs1;
        w[VS2_LSB    +: 5] = vs2;
        return w;
    endfunction

    function automatic logic is_legal_op(input logic [4:0] opcode);
        return (opcode[4] == 1'b0);
    endfunction

    function automatic logic is_ldst(input logic [4:0] opcode);
        return (opcode == OP_VLOAD) || (opcode == OP_VSTORE);
    endfunction

endpackage

// File: rtl/vec_instr_fifo.sv
// Synchronous FIFO with wrap-bit pointers; full/empty derived from wrap bit plus index compare.
// Head data is read combinationally so the consumer sees the oldest word with no extra latency.
module vec_instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head_data = mem[rd_ptr[AW-1:0]];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count     = wr_ptr - rd_ptr;

endmodule

// File: rtl/vec_instr_encoder.sv
// Packs host vector ops into 32-bit words, queues them, and issues them to the decoder
// with an ISSUE/GAP FSM that inserts idle cycles after every load/store leaves the queue.
module vec_instr_encoder
    import vec_isa_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int LS_GAP = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [4:0]              op_opcode,
    input  logic [4:0]              op_vd,
    input  logic [4:0]              op_vs1,
    input  logic [4:0]              op_vs2,
    output logic [31:0]             instruction,
    output logic                    instruction_valid,
    input  logic                    instruction_ready,
    output logic                    illegal_op,
    input  logic                    clear_err,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    state_dbg
);

    localparam int GW = (LS_GAP < 1) ? 1 : $clog2(LS_GAP + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(LS_GAP);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    // Handshakes: a transfer happens on a cycle where valid && ready are both high at the
    // clock edge. Host side: op_ready depends only on occupancy, never on op_valid.
    // Decoder side: once instruction_valid rises it stays high with a constant word
    // until instruction_ready is seen.
    logic         accept;
    logic         push;
    logic         dequeue;
    logic         fifo_full;
    logic         fifo_empty;
    logic [31:0]  fifo_head;

    issue_state_t state, state_next;
    logic [GW-1:0] gap_cnt, gap_next;

    assign op_ready = !fifo_full;
    assign accept   = op_valid && op_ready;
    assign push     = accept && is_legal_op(op_opcode);

    vec_instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (encode_instr(op_opcode, op_vd, op_vs1, op_vs2)),
        .pop       (dequeue),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    assign instruction_valid = (state == ST_ISSUE) && !fifo_empty;
    assign dequeue           = instruction_valid && instruction_ready;
    assign instruction       = instruction_valid ? fifo_head : 32'h0;
    assign state_dbg         = (state == ST_GAP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_ISSUE;
            gap_cnt <= '0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_next;
        end
    end

    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        case (state)
            ST_ISSUE: begin
                if (dequeue && is_ldst(fifo_head[OPCODE_LSB +: 5]) && (LS_GAP > 0)) begin
                    state_next = ST_GAP;
                    gap_next   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                gap_next = gap_cnt - GAP_ONE;
                if (gap_cnt == GAP_ONE) state_next = ST_ISSUE;
            end
            default: state_next = ST_ISSUE;
        endcase
    end

    // Setting on an illegal accept takes priority over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_op <= 1'b0;
        end else if (accept && !is_legal_op(op_opcode)) begin
            illegal_op <= 1'b1;
        end else if (clear_err) begin
            illegal_op <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vec_instr_encoder.sv
// Bench for vec_instr_encoder: directed corner sequences, a vector table and random ops,
// all checked through an expected-word queue popped on each decoder-side transfer.
module tb_vec_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid;
    logic        op_ready;
    logic [4:0]  op_opcode;
    logic [4:0]  op_vd;
    logic [4:0]  op_vs1;
    logic [4:0]  op_vs2;
    logic [31:0] instruction;
    logic        instruction_valid;
    logic        instruction_ready;
    logic        illegal_op;
    logic        clear_err;
    logic [2:0]  count;
    logic        state_dbg;

    int checks = 0;
    int passes = 0;
    logic [31:0] exp_q[$];

    typedef struct packed {
        logic [4:0]  opc;
        logic [4:0]  vd;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[6];

    vec_instr_encoder #(.DEPTH(DEPTH), .LS_GAP(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .op_valid          (op_valid),
        .op_ready          (op_ready),
        .op_opcode         (op_opcode),
        .op_vd             (op_vd),
        .op_vs1            (op_vs1),
        .op_vs2            (op_vs2),
        .instruction       (instruction),
        .instruction_valid (instruction_valid),
        .instruction_ready (instruction_ready),
        .illegal_op        (illegal_op),
        .clear_err         (clear_err),
        .count             (count),
        .state_dbg         (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] model_word(input logic [4:0] opc, input logic [4:0] vd,
                                               input logic [4:0] vs1, input logic [4:0] vs2);
        return {opc, 1'b0, vd, vs1, vs2, 11'b0};
    endfunction

    // ---------------- driver ----------------
    task automatic send_op(input logic [4:0] opc, input logic [4:0] vd, input logic [4:0] vs1,
                           input logic [4:0] vs2, input logic [31:0] w);
        int n;
        n = 0;
        @(posedge clk); #1;
        op_opcode = opc; op_vd = vd; op_vs1 = vs1; op_vs2 = vs2;
        op_valid  = 1'b1;
        @(negedge clk);
        while (!op_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) check("send_timeout", 32'(op_ready), 32'd1);
        else if (opc[4] == 1'b0) exp_q.push_back(w);
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(posedge clk); #1;
        instruction_ready = 1'b1;
        while ((exp_q.size() != 0 || count != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()) + 32'(count), 32'd0);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (instruction_valid && instruction_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL sb_unexpected: got word 0x%08h expected none at %0t", instruction, $time);
                end else begin
                    check("sb_word", instruction, exp_q.pop_front());
                end
            end else if (!instruction_valid) begin
                check("idle_zero", instruction, 32'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic acc;
        logic [31:0] w0;
        logic [4:0] r_opc, r_vd, r_vs1, r_vs2;

        op_valid = 1'b0; op_opcode = '0; op_vd = '0; op_vs1 = '0; op_vs2 = '0;
        instruction_ready = 1'b0; clear_err = 1'b0;

        vecs[0] = '{opc: 5'd2,  vd: 5'd3,  vs1: 5'd1,  vs2: 5'd2,  word: 32'h10611000};
        vecs[1] = '{opc: 5'd0,  vd: 5'd5,  vs1: 5'd7,  vs2: 5'd0,  word: 32'h00A70000};
        vecs[2] = '{opc: 5'd1,  vd: 5'd31, vs1: 5'd31, vs2: 5'd31, word: 32'h0BFFF800};
        vecs[3] = '{opc: 5'd15, vd: 5'd0,  vs1: 5'd0,  vs2: 5'd0,  word: 32'h78000000};
        vecs[4] = '{opc: 5'd7,  vd: 5'd1,  vs1: 5'd2,  vs2: 5'd3,  word: 32'h38221800};
        vecs[5] = '{opc: 5'd12, vd: 5'd10, vs1: 5'd20, vs2: 5'd30, word: 32'h6154F000};

        // reset state
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(instruction_valid), 32'd0);
        check("rst_instr", instruction, 32'h0);
        check("rst_op_ready", 32'(op_ready), 32'd1);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // latency 1: VADD into empty FIFO
        instruction_ready = 1'b1;
        op_opcode = 5'd2; op_vd = 5'd3; op_vs1 = 5'd1; op_vs2 = 5'd2; op_valid = 1'b1;
        @(negedge clk);
        check("t1_op_ready", 32'(op_ready), 32'd1);
        check("t1_pre_valid", 32'(instruction_valid), 32'd0);
        exp_q.push_back(32'h10611000);
        @(posedge clk); #1 op_valid = 1'b0;
        @(negedge clk);
        check("t1_valid", 32'(instruction_valid), 32'd1);
        check("t1_word", instruction, 32'h10611000);
        @(negedge clk);
        check("t1_one_cycle", 32'(instruction_valid), 32'd0);

        // fill to full with ready low, 5th op held, then stream out one per cycle
        @(posedge clk); #1 instruction_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send_op(5'(2 + i), 5'(i), 5'(i + 8), 5'(i + 16), model_word(5'(2 + i), 5'(i), 5'(i + 8), 5'(i + 16)));
        w0 = model_word(5'd2, 5'd0, 5'd8, 5'd16);
        @(negedge clk);
        check("t2_full_ready", 32'(op_ready), 32'd0);
        check("t2_full_count", 32'(count), 32'd4);
        @(posedge clk); #1;
        op_opcode = 5'd6; op_vd = 5'd9; op_vs1 = 5'd10; op_vs2 = 5'd11; op_valid = 1'b1;
        exp_q.push_back(model_word(5'd6, 5'd9, 5'd10, 5'd11));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t2_held_ready", 32'(op_ready), 32'd0);
            check("t2_held_count", 32'(count), 32'd4);
            check("t2_head_stable", instruction, w0);
        end
        @(posedge clk); #1 instruction_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t2_stream_valid", 32'(instruction_valid), 32'd1);
            acc = op_valid && op_ready;
            @(posedge clk); #1;
            if (acc) op_valid = 1'b0;
        end
        @(negedge clk);
        check("t2_done_valid", 32'(instruction_valid), 32'd0);
        check("t2_done_count", 32'(count), 32'd0);
        check("t2_5th_taken", 32'(op_valid), 32'd0);

        // load/store issue bubble
        @(posedge clk); #1 instruction_ready = 1'b0;
        send_op(5'd0, 5'd5, 5'd7, 5'd0, 32'h00A70000);
        send_op(5'd5, 5'd1, 5'd2, 5'd3, 32'h28221800);
        @(posedge clk); #1 instruction_ready = 1'b1;
        @(negedge clk);
        check("t3_load_valid", 32'(instruction_valid), 32'd1);
        check("t3_load_word", instruction, 32'h00A70000);
        @(negedge clk);
        check("t3_gap1_valid", 32'(instruction_valid), 32'd0);
        check("t3_gap1_state", 32'(state_dbg), 32'd1);
        @(negedge clk);
        check("t3_gap2_valid", 32'(instruction_valid), 32'd0);
        @(negedge clk);
        check("t3_vand_valid", 32'(instruction_valid), 32'd1);
        check("t3_vand_word", instruction, 32'h28221800);
        @(negedge clk);
        check("t3_after_valid", 32'(instruction_valid), 32'd0);

        // illegal opcode: dropped, sticky flag, set beats clear
        @(posedge clk); #1;
        op_opcode = 5'b10000; op_vd = 5'd1; op_vs1 = 5'd1; op_vs2 = 5'd1; op_valid = 1'b1;
        @(negedge clk);
        check("t4_op_ready", 32'(op_ready), 32'd1);
        check("t4_flag_before", 32'(illegal_op), 32'd0);
        @(posedge clk); #1 op_valid = 1'b0;
        @(negedge clk);
        check("t4_count", 32'(count), 32'd0);
        check("t4_no_valid", 32'(instruction_valid), 32'd0);
        check("t4_flag_set", 32'(illegal_op), 32'd1);
        repeat (2) @(negedge clk);
        check("t4_flag_sticky", 32'(illegal_op), 32'd1);
        @(posedge clk); #1;
        op_opcode = 5'b11111; op_valid = 1'b1; clear_err = 1'b1;
        @(posedge clk); #1 op_valid = 1'b0;
        @(negedge clk);
        check("t4_set_wins", 32'(illegal_op), 32'd1);
        @(posedge clk); #1 clear_err = 1'b0;
        @(negedge clk);
        check("t4_cleared", 32'(illegal_op), 32'd0);
        check("t4_count_after", 32'(count), 32'd0);

        // stall stability while pushing
        @(posedge clk); #1 instruction_ready = 1'b0;
        w0 = model_word(5'd3, 5'd4, 5'd5, 5'd6);
        send_op(5'd3, 5'd4, 5'd5, 5'd6, w0);
        @(negedge clk);
        check("t5_first_word", instruction, w0);
        for (int i = 0; i < 3; i++) begin
            send_op(5'(8 + i), 5'(i), 5'(i), 5'(i), model_word(5'(8 + i), 5'(i), 5'(i), 5'(i)));
            @(negedge clk);
            check("t5_stable_word", instruction, w0);
            check("t5_stable_valid", 32'(instruction_valid), 32'd1);
            check("t5_count_inc", 32'(count), 32'(i + 2));
        end
        wait_drain();

        // reset in the middle of a GAP with 3 entries queued
        @(posedge clk); #1 instruction_ready = 1'b0;
        send_op(5'd0, 5'd2, 5'd3, 5'd4, model_word(5'd0, 5'd2, 5'd3, 5'd4));
        for (int i = 0; i < 3; i++)
            send_op(5'd4, 5'(i), 5'd1, 5'd1, model_word(5'd4, 5'(i), 5'd1, 5'd1));
        @(posedge clk); #1 instruction_ready = 1'b1;
        @(negedge clk);
        check("t6_load_valid", 32'(instruction_valid), 32'd1);
        @(negedge clk);
        check("t6_in_gap", 32'(state_dbg), 32'd1);
        check("t6_count3", 32'(count), 32'd3);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(instruction_valid), 32'd0);
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_op_ready", 32'(op_ready), 32'd1);
        check("t6_rst_state", 32'(state_dbg), 32'd0);
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        op_opcode = 5'd15; op_vd = 5'd0; op_vs1 = 5'd0; op_vs2 = 5'd0; op_valid = 1'b1;
        @(negedge clk);
        check("t6_pre_valid", 32'(instruction_valid), 32'd0);
        exp_q.push_back(32'h78000000);
        @(posedge clk); #1 op_valid = 1'b0;
        @(negedge clk);
        check("t6_post_valid", 32'(instruction_valid), 32'd1);
        check("t6_post_word", instruction, 32'h78000000);
        wait_drain();

        // vector table
        for (int i = 0; i < 6; i++)
            send_op(vecs[i].opc, vecs[i].vd, vecs[i].vs1, vecs[i].vs2, vecs[i].word);
        wait_drain();

        // random ops with random back-pressure
        for (int i = 0; i < 40; i++) begin
            r_opc = 5'($urandom_range(0, 19));
            r_vd  = 5'($urandom_range(0, 31));
            r_vs1 = 5'($urandom_range(0, 31));
            r_vs2 = 5'($urandom_range(0, 31));
            instruction_ready = (count >= 3'd3) ? 1'b1 : 1'($urandom_range(0, 1));
            send_op(r_opc, r_vd, r_vs1, r_vs2, model_word(r_opc, r_vd, r_vs1, r_vs2));
        end
        wait_drain();

        @(posedge clk); #1 clear_err = 1'b1;
        @(posedge clk); #1 clear_err = 1'b0;
        @(negedge clk);
        check("final_flag_clear", 32'(illegal_op), 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
